// File: rtl/timer_ctrl_pkg.sv
// Shared types and default sizes for the timer controller.
//   state_e   : controller state, encoding visible on the state output port
//   WIDTH_DEF : default counter/limit width
//   PRE_W_DEF : default prescaler width (used with TIMER_CTRL_PRESCALE_EN)
package timer_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned PRE_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/timer_ctrl_cnt.sv
// WIDTH-bit up-counter datapath driven by the timer controller.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clr       : load zero (wins over en)
//   en        : advance by one
//   count     : registered counter value
module timer_ctrl_cnt
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear has priority over advance.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for an up-counter: start/stop/hold, programmable
// terminal count, one-shot and periodic modes.
// Optional prescaler enabled by defining TIMER_CTRL_PRESCALE_EN.
// Ports:
//   clk, rstn              : clock, synchronous active-low reset
//   cfg_we                 : config write, honoured in IDLE/DONE only
//   cfg_limit, cfg_periodic: terminal count and mode (1 = periodic)
//   cfg_prescale           : prescaler terminal value (prescale build only)
//   start, stop, hold, ack : control strobes / hold level / done clear
//   count                  : current counter value
//   busy, done             : decoded from state (RUN|HOLD, DONE)
//   tc_pulse               : registered one-cycle terminal-count pulse
//   state                  : IDLE=0, RUN=1, HOLD=2, DONE=3
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
`ifdef TIMER_CTRL_PRESCALE_EN
    ,
    parameter int unsigned PRE_W = PRE_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_periodic,
`ifdef TIMER_CTRL_PRESCALE_EN
    input  logic [PRE_W-1:0] cfg_prescale,
`endif
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done,
    output logic [1:0]       state
);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] limit_d, limit_q;
    logic             periodic_d, periodic_q;
    logic             tc_pulse_d, tc_pulse_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_val;
    logic             cfg_ok;
    logic             tick;

    // Config and fresh starts are only accepted while not running.
    assign cfg_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [PRE_W-1:0] pre_d, pre_q;
    logic [PRE_W-1:0] prescale_d, prescale_q;
    logic             run_adv;

    // Counting slot in RUN, or on the edge that leaves HOLD.
    assign run_adv = !stop && !hold &&
                     ((state_q == ST_RUN) || (state_q == ST_HOLD));
    assign tick    = (pre_q == prescale_q);

    // Prescaler: restarts on accepted start/stop, frozen outside counting slots.
    always_comb begin
        pre_d      = pre_q;
        prescale_d = prescale_q;
        if (cfg_we && cfg_ok) begin
            prescale_d = cfg_prescale;
        end
        if (stop || (start && cfg_ok)) begin
            pre_d = '0;
        end else if (run_adv) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_q      <= '0;
            prescale_q <= '0;
        end else begin
            pre_q      <= pre_d;
            prescale_q <= prescale_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Next-state, counter control and terminal-count decode.
    // Leaving HOLD counts on the same edge so the period stretches by exactly
    // the number of held edges.
    always_comb begin
        state_d    = state_q;
        tc_pulse_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        if (cfg_we && cfg_ok) begin
            limit_d    = cfg_limit;
            periodic_d = cfg_periodic;
        end
        if (stop) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        cnt_clr = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        cnt_clr = 1'b1;
                    end else if (ack) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (tick) begin
                            if (cnt_val == limit_q) begin
                                tc_pulse_d = 1'b1;
                                if (periodic_q) begin
                                    cnt_clr = 1'b1;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                cnt_en = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            limit_q    <= '1;
            periodic_q <= 1'b0;
            tc_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            tc_pulse_q <= tc_pulse_d;
        end
    end

    timer_ctrl_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_val)
    );

    assign count    = cnt_val;
    assign state    = state_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign done     = (state_q == ST_DONE);
    assign tc_pulse = tc_pulse_q;

endmodule
